// File: rtl/viterbi_pkg.sv
// Shared Viterbi-chain definitions: default code parameters, encoder FSM
// states and the parity helper used by the encoder and branch metric unit.
package viterbi_pkg;

    localparam int K_DEFAULT = 3;
    localparam logic [K_DEFAULT-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K_DEFAULT-1:0] G1_DEFAULT = 3'b101;

    // Wide enough for any practical constraint length.
    localparam int PARITY_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DONE
    } enc_fsm_e;

    function automatic logic parity(input logic [PARITY_W-1:0] v,
                                    input logic [PARITY_W-1:0] g);
        return ^(v & g);
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / symbol-pair-out handshake bundle of the convolutional encoder.
interface conv_encoder_if;

    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out0;
    logic out1;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out0, out1, out_valid, out_last
    );

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out0, out1, out_valid, out_last
    );

endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder; each frame is followed by
// K-1 zero tail bits so the trellis always terminates in state 0.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int             K         = K_DEFAULT,
    parameter logic [K-1:0]   G0        = G0_DEFAULT,
    parameter logic [K-1:0]   G1        = G1_DEFAULT,
    parameter int             FRAME_LEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    conv_encoder_if.slave       bus,
    output logic                busy,
    output logic [K-2:0]        enc_state
);

    localparam int BIT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TAIL_W = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_LEN - 1);
    localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(K - 2);

    enc_fsm_e            r_state;
    enc_fsm_e            w_next_state;
    logic [K-2:0]        r_sr;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [TAIL_W-1:0]   r_tail_cnt;
    logic                r_out0;
    logic                r_out1;
    logic                r_out_valid;
    logic                r_out_last;

    logic                w_slot_free;
    logic                w_step;
    logic                w_u;
    logic                w_last_step;
    logic                w_in_ready;
    logic [K-1:0]        w_v;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_v         = {w_u, r_sr};

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_step       = 1'b0;
        w_u          = 1'b0;
        w_last_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                w_in_ready = w_slot_free;
                w_u        = bus.in_bit;
                w_step     = bus.in_valid && w_slot_free;
                if (w_step && (r_bit_cnt == LAST_BIT)) w_next_state = ST_TAIL;
            end
            ST_TAIL: begin
                w_step = w_slot_free;
                if (w_slot_free && (r_tail_cnt == LAST_TAIL)) begin
                    w_last_step  = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            r_out0      <= 1'b0;
            r_out1      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
            end
            if (w_step) begin
                r_out0      <= parity(PARITY_W'(w_v), PARITY_W'(G0));
                r_out1      <= parity(PARITY_W'(w_v), PARITY_W'(G1));
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_step;
                r_sr        <= w_v[K-1:1];
                if (r_state == ST_DATA) begin
                    r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                    r_tail_cnt <= '0;
                end else begin
                    r_tail_cnt <= r_tail_cnt + TAIL_W'(1);
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out0      = r_out0;
    assign bus.out1      = r_out1;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign busy          = (r_state != ST_IDLE);
    assign enc_state     = r_sr;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames plus randomized frames
// checked against a convolution-sum reference model.
module tb_conv_encoder;
    import viterbi_pkg::*;

    localparam int           K    = K_DEFAULT;
    localparam logic [K-1:0] G0   = G0_DEFAULT;
    localparam logic [K-1:0] G1   = G1_DEFAULT;
    localparam int           FL_A = 4;
    localparam int           FL_B = 1;

    logic clk = 1'b0;
    logic rst_n, start_a, start_b, in_bit, in_valid, out_ready;
    logic busy_a, busy_b;
    logic [K-2:0] state_a, state_b;

    conv_encoder_if if_a ();
    conv_encoder_if if_b ();

    assign if_a.in_bit    = in_bit;
    assign if_a.in_valid  = in_valid;
    assign if_a.out_ready = out_ready;
    assign if_b.in_bit    = in_bit;
    assign if_b.in_valid  = in_valid;
    assign if_b.out_ready = out_ready;

    conv_encoder #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL_A)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .bus(if_a.slave),
        .busy(busy_a), .enc_state(state_a)
    );

    conv_encoder #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL_B)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .bus(if_b.slave),
        .busy(busy_b), .enc_state(state_b)
    );

    always #5 clk = ~clk;

    int sel = 0;
    logic w_in_ready, w_out0, w_out1, w_out_valid, w_out_last, w_busy;
    logic [K-2:0] w_enc_state;

    always_comb begin
        w_in_ready  = if_a.in_ready;
        w_out0      = if_a.out0;
        w_out1      = if_a.out1;
        w_out_valid = if_a.out_valid;
        w_out_last  = if_a.out_last;
        w_busy      = busy_a;
        w_enc_state = state_a;
        if (sel == 1) begin
            w_in_ready  = if_b.in_ready;
            w_out0      = if_b.out0;
            w_out1      = if_b.out1;
            w_out_valid = if_b.out_valid;
            w_out_last  = if_b.out_last;
            w_busy      = busy_b;
            w_enc_state = state_b;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] got_pairs[$];
    logic       got_last[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output symbol t is the mod-2 convolution of the input stream with each
    // generator; tap bit K-1-j weights the input j steps in the past.
    function automatic logic [1:0] model_pair(input logic [127:0] x, input int t);
        logic o0, o1;
        o0 = 1'b0;
        o1 = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (t - j >= 0) begin
                o0 ^= G0[K-1-j] & x[t-j];
                o1 ^= G1[K-1-j] & x[t-j];
            end
        end
        return {o0, o1};
    endfunction

    // Memory after s steps holds the last K-1 inputs, newest at the MSB.
    function automatic logic [K-2:0] model_sr(input logic [127:0] x, input int s);
        logic [K-2:0] r;
        r = '0;
        for (int m = 0; m < K - 1; m++)
            if (s - 1 - m >= 0) r[K-2-m] = x[s-1-m];
        return r;
    endfunction

    task automatic run_frame(input int which, input int n, input logic [63:0] bits,
                             input int ready_mode, input bit gaps,
                             input bit poke_start, input int abort_at);
        logic [127:0] x;
        int  total, idx, k, it, last_it;
        bit  stall, done;
        logic h0, h1, hl;
        x = '0;
        for (int i = 0; i < n; i++) x[i] = bits[i];
        total = n + K - 1;
        idx = 0; k = 0; it = 0; last_it = 0;
        stall = 1'b0; done = 1'b0;
        h0 = 1'b0; h1 = 1'b0; hl = 1'b0;
        sel = which;
        got_pairs.delete();
        got_last.delete();

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (which == 1) start_b = 1'b1;
        else            start_a = 1'b1;

        while (!done && it < 200) begin
            @(negedge clk);
            it++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (abort_at > 0 && idx == abort_at) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", w_out_valid, 0);
                check("rst_busy", w_busy, 0);
                check("rst_in_ready", w_in_ready, 0);
                check("rst_enc_state", w_enc_state, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (poke_start && (it % 3 == 0)) begin
                if (which == 1) start_b = 1'b1;
                else            start_a = 1'b1;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((it % 4) <= 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (idx < n) && (!gaps || ($urandom_range(0, 3) != 0));
            in_bit   = x[idx];
            #1;
            check("busy_in_frame", w_busy, 1);
            if (stall)
                check("hold_pair", {w_out_valid, w_out0, w_out1, w_out_last},
                      {1'b1, h0, h1, hl});
            check("enc_state", w_enc_state, model_sr(x, k + int'(w_out_valid)));
            if (w_out_valid && !out_ready) check("in_ready_stall", w_in_ready, 0);
            stall = w_out_valid && !out_ready;
            h0 = w_out0; h1 = w_out1; hl = w_out_last;
            if (w_out_valid && out_ready) begin
                if (k < total) begin
                    check("pair", {w_out0, w_out1}, model_pair(x, k));
                    check("last", w_out_last, (k == total - 1));
                end else begin
                    check("pair_count", k + 1, total);
                end
                got_pairs.push_back({w_out0, w_out1});
                got_last.push_back(w_out_last);
                k++;
                if (k == total) begin
                    done = 1'b1;
                    last_it = it;
                end
            end
            if (in_valid && w_in_ready) idx++;
        end
        if (!done) check("timeout_pairs", k, total);

        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        in_valid = 1'b0;
        #1;
        check("end_busy", w_busy, 0);
        check("end_out_valid", w_out_valid, 0);
        check("end_enc_state", w_enc_state, 0);
        if (ready_mode == 0 && !gaps) check("throughput_cycles", last_it, total + 1);
    endtask

    task automatic check_literal(input string tag, input logic [11:0] tab, input int npairs);
        check({tag, "_count"}, got_pairs.size(), npairs);
        for (int i = 0; i < npairs && i < got_pairs.size(); i++) begin
            check(tag, got_pairs[i], tab[2*(npairs-1-i) +: 2]);
            check({tag, "_last"}, got_last[i], (i == npairs - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        in_bit = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_state_a",
              {w_out0, w_out1, w_out_valid, w_out_last, w_in_ready, w_busy, w_enc_state}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Input offered while idle must be neither accepted nor encoded.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit = 1'b1;
            out_ready = 1'b1;
            #1;
            check("idle_in_ready", w_in_ready, 0);
            check("idle_out_valid", w_out_valid, 0);
            check("idle_busy", w_busy, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        run_frame(0, FL_A, 64'b1101, 0, 1'b0, 1'b0, 0);
        check_literal("dir_basic", 12'b11_10_00_01_01_11, 6);

        run_frame(0, FL_A, 64'b1101, 1, 1'b0, 1'b0, 0);
        check_literal("dir_stall", 12'b11_10_00_01_01_11, 6);

        run_frame(0, FL_A, 64'b0000, 0, 1'b0, 1'b0, 0);
        check_literal("dir_zero", 12'b00_00_00_00_00_00, 6);

        run_frame(0, FL_A, 64'b1101, 0, 1'b0, 1'b0, 2);
        run_frame(0, FL_A, 64'b1101, 0, 1'b0, 1'b0, 0);
        check_literal("dir_after_reset", 12'b11_10_00_01_01_11, 6);

        run_frame(0, FL_A, 64'b1101, 2, 1'b1, 1'b1, 0);
        check_literal("dir_start_poke", 12'b11_10_00_01_01_11, 6);

        run_frame(1, FL_B, 64'b1, 0, 1'b0, 1'b0, 0);
        check_literal("dir_len1", 12'b000000_11_10_11, 3);

        for (int f = 0; f < 8; f++)
            run_frame(0, FL_A, {$urandom, $urandom}, 2, 1'b1, 1'b0, 0);
        for (int f = 0; f < 4; f++)
            run_frame(1, FL_B, {$urandom, $urandom}, 2, 1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2 feed-forward convolutional encoder. It produces the symbol pairs that the Viterbi add-compare-select and survivor path decoder (SPDu) chain consumes.
- Accepts a frame of FRAME_LEN information bits over a valid/ready handshake.
- Appends K-1 zero tail bits so every frame terminates in trellis state 0. This is the precondition SPDu traceback relies on.
- Sits between the bit source and the channel model or decoder input in the Viterbi test system.

Parameters:
- K, 3, constraint length; encoder memory is K-1 bits (4 trellis states at default).
- G0, 3'b111, generator polynomial for out0; bit K-1 taps the current input, bit 0 taps the oldest memory bit.
- G1, 3'b101, generator polynomial for out1, same tap ordering as G0.
- FRAME_LEN, 64, information bits per frame, must be >= 1.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a frame; honoured only in IDLE.
- in_bit, input, 1, information bit.
- in_valid, input, 1, in_bit is valid.
- in_ready, output, 1, encoder accepts in_bit this cycle.
- out0, output, 1, G0 parity symbol.
- out1, output, 1, G1 parity symbol.
- out_valid, output, 1, out0/out1 hold a valid symbol pair.
- out_ready, input, 1, downstream accepts the symbol pair.
- out_last, output, 1, qualifies the final tail symbol pair of the frame.
- busy, output, 1, high whenever the FSM is not in IDLE.
- enc_state, output, K-1, current encoder memory, for debug/trellis checking.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, memory sr=0, bit counter=0, tail counter=0. Outputs out0=out1=out_valid=out_last=in_ready=busy=0, enc_state=0. Reset mid-frame discards the frame and any held symbol.
- Output slot free: slot_free = !out_valid || out_ready.
- Encode step with input u: v = {u, sr} (K bits, u at MSB).
  - out0 <= XOR-reduce(v & G0); out1 <= XOR-reduce(v & G1).
  - sr <= {u, sr[K-2:1]}, i.e. newest bit at the MSB.
  - out_valid <= 1.
- Output register: if out_valid && out_ready and no new step this cycle, then out_valid <= 0 and out_last <= 0. While out_valid && !out_ready, out0/out1/out_last hold stable.
- IDLE:
  - in_ready=0.
  - On start: sr <= 0, bit counter <= 0, go to DATA; busy asserts the next cycle.
- DATA:
  - in_ready = slot_free (combinational).
  - Each in_valid && in_ready is one encode step with u=in_bit, and increments the bit counter.
  - When the FRAME_LEN-th bit is accepted, go to TAIL with tail counter=0.
- TAIL:
  - in_ready=0.
  - Whenever slot_free, perform an encode step with u=0 and increment the tail counter.
  - On the (K-1)-th tail step, set out_last <= 1 with that pair and go to DONE.
- DONE:
  - Wait until the last pair is accepted (out_valid && out_ready), then go to IDLE.
  - sr is guaranteed 0 on entry to DONE.
- start outside IDLE is ignored. start and reset asserted together: reset wins.
- Latency: symbol pair valid 1 cycle after input acceptance; full throughput of 1 pair/cycle when out_ready is held high.
- Per frame: exactly FRAME_LEN+K-1 pairs, exactly one with out_last.
- enc_state = sr at all times.

Decomposition:
- Shared viterbi_pkg:
  - default K/G0/G1 constants, also used by the branch metric unit and SPDu;
  - FSM state enum {IDLE, DATA, TAIL, DONE};
  - parity function (XOR-reduce of a masked vector).
- No sub-module: the encode datapath is a few gates, and the FSM plus counters fit one module.

Test Plan:
- Default G, FRAME_LEN=4, out_ready=1, start then in_bit 1,0,1,1 back-to-back:
  - pairs (out0,out1) = 11,10,00,01,01,11;
  - out_last only on the 6th pair; enc_state=0 afterwards; busy drops after the last handshake.
- Same frame with out_ready toggling 1,0,0,1,...:
  - pairs stay stable while stalled, in_ready=0 during the stall;
  - identical 6-pair sequence, no duplicates or losses.
- All-zero frame (FRAME_LEN=4): six 00 pairs, enc_state stays 0 throughout.
- Assert reset low after the 2nd accepted bit:
  - out_valid, busy, in_ready and enc_state go to 0 immediately;
  - a new start then reproduces the first scenario's sequence.
- Other events:
  - start pulses during DATA/TAIL: ignored, pair count unchanged;
  - in_valid while IDLE: no acceptance, no output.
- FRAME_LEN=1 with input 1: pairs 11,10,11, last on the 3rd pair.
